// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder with a programmable access latency.
// Optional feature macro DMEM_ERR_EN: misalignment / dual-enable error reporting on err.
module dmem_resp #(
    parameter int N       = 64,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         DM_ready,
    output logic         busy,
    output logic         err
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [N-1:0]  data;
        logic          store;
        logic          skip;
    } req_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    req_t         req;
    logic [N-1:0] mem [DEPTH];

    logic accept, access, conflict, misaligned;

    assign accept   = (state == IDLE) && (DM_writeEnable || DM_readEnable);
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign conflict = DM_writeEnable && DM_readEnable;

`ifdef DMEM_ERR_EN
    assign misaligned = (DM_addr[2:0] != 3'd0);
    logic unused_addr;
    assign unused_addr = ^DM_addr[N-1:IW+3];
`else
    // Low address bits select nothing: misaligned accesses hit the containing word.
    assign misaligned = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{DM_addr[N-1:IW+3], DM_addr[2:0], conflict};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req         <= '0;
            DM_readData <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
                // Dual enables resolve to a store since store follows the write enable alone.
                req <= '{idx:   DM_addr[IW+2:3],
                         data:  DM_writeData,
                         store: DM_writeEnable,
                         skip:  misaligned};
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !req.store && !req.skip)
                DM_readData <= mem[req.idx];
        end
    end

    // Array is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (access && req.store && !req.skip)
            mem[req.idx] <= req.data;
    end

`ifdef DMEM_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (accept && (conflict || misaligned))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    assign DM_ready = (state == DONE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized + directed bench for dmem_resp with a scoreboard monitor
// comparing load/store completions against an array-based reference model.
module tb_dmem_resp;
    localparam int N     = 64;
    localparam int DEPTH = 32;
    localparam int LAT   = 2;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] DM_addr = '0;
    logic [N-1:0] DM_writeData = '0;
    logic         DM_writeEnable = 1'b0;
    logic         DM_readEnable = 1'b0;
    logic [N-1:0] DM_readData;
    logic         DM_ready;
    logic         busy;
    logic         err;

    dmem_resp #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .DM_addr(DM_addr),
        .DM_writeData(DM_writeData),
        .DM_writeEnable(DM_writeEnable),
        .DM_readEnable(DM_readEnable),
        .DM_readData(DM_readData),
        .DM_ready(DM_ready),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain word array, last load result, sticky error.
    logic [N-1:0] mdl_mem [DEPTH];
    logic [N-1:0] mdl_rd  = '0;
    logic         mdl_err = 1'b0;
    logic [N-1:0] sb_q [$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic we, input logic re, input logic [N-1:0] a, input logic [N-1:0] d);
        int idx;
        bit mis;
        idx = int'((a >> 3) % DEPTH);
        mis = (a % 8) != 0;
        if (ERR_EN && ((we && re) || mis)) mdl_err = 1'b1;
        if (!(ERR_EN && mis)) begin
            if (we) mdl_mem[idx] = d;
            else    mdl_rd = mdl_mem[idx];
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the return to IDLE.
    task automatic issue(input logic we, input logic re, input logic [N-1:0] a,
                         input logic [N-1:0] d, input bit junk);
        DM_writeEnable = we;
        DM_readEnable  = re;
        DM_addr        = a;
        DM_writeData   = d;
        @(posedge clk);
        model(we, re, a, d);
        sb_q.push_back(mdl_rd);
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (junk && k <= LAT) begin
                DM_writeEnable = 1'($urandom);
                DM_readEnable  = 1'($urandom);
                DM_addr        = {$urandom, $urandom};
                DM_writeData   = {$urandom, $urandom};
            end else begin
                DM_writeEnable = 1'b0;
                DM_readEnable  = 1'b0;
            end
            check("busy", N'(busy), N'(k <= LAT));
            check("ready", N'(DM_ready), N'(k == LAT));
        end
        check("err", N'(err), N'(mdl_err));
    endtask

    task automatic reset_mid_store(input logic [N-1:0] a, input logic [N-1:0] d);
        DM_writeEnable = 1'b1;
        DM_readEnable  = 1'b0;
        DM_addr        = a;
        DM_writeData   = d;
        @(posedge clk);
        @(posedge clk);
        DM_writeEnable = 1'b0;
        #1 reset = 1'b0;
        #1;
        mdl_rd  = '0;
        mdl_err = 1'b0;
        check("rst_busy", N'(busy), '0);
        check("rst_ready", N'(DM_ready), '0);
        check("rst_rdata", DM_readData, '0);
        check("rst_err", N'(err), '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Scoreboard monitor: every completion pops one expectation.
    always @(negedge clk) begin
        if (reset && DM_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: got pulse expected none at %0t", $time);
            end else begin
                check("rdata", DM_readData, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic we, re;
        logic [N-1:0] a;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rdata", DM_readData, '0);
            check("idle_ready", N'(DM_ready), '0);
            check("idle_busy", N'(busy), '0);
            check("idle_err", N'(err), '0);
        end

        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, 1'b0, N'(i * 8), {$urandom, $urandom}, 1'b0);

        issue(1'b1, 1'b0, 64'h18, 64'hDEAD_BEEF_0123_4567, 1'b0);
        issue(1'b0, 1'b1, 64'h18, '0, 1'b0);
        issue(1'b0, 1'b1, 64'h18 + DEPTH * 8, '0, 1'b0);

        // Junk inputs during WAIT/DONE must not disturb the latched load.
        issue(1'b0, 1'b1, 64'h08, '0, 1'b1);
        issue(1'b0, 1'b1, 64'h10, '0, 1'b0);

        issue(1'b1, 1'b0, 64'h20, 64'h5, 1'b0);
        reset_mid_store(64'h20, 64'h1);
        issue(1'b0, 1'b1, 64'h20, '0, 1'b0);

        issue(1'b1, 1'b0, 64'h0C, 64'hABCD_0000_1234_5678, 1'b0);
        issue(1'b0, 1'b1, 64'h08, '0, 1'b0);
        issue(1'b0, 1'b1, 64'h10, '0, 1'b0);

        issue(1'b1, 1'b1, 64'h28, 64'h7, 1'b0);
        issue(1'b0, 1'b1, 64'h28, '0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            re = !we || 1'($urandom_range(0, 3) == 0);
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a[2:0] = 3'd0;
            issue(we, re, a, {$urandom, $urandom}, 1'($urandom));
        end

        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_responses: got %0d expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
